// File: rtl/pwm_deadtime_pkg.sv
// pwm_deadtime_pkg: shared PWM definitions for the dead-time stage.
package pwm_deadtime_pkg;
    localparam int unsigned DT_WIDTH = 8;
    // Dead-time registers sit directly after the 6'h00-6'h0D generator map.
    localparam logic [5:0] REG_DT_RISE = 6'h0E;
    localparam logic [5:0] REG_DT_FALL = 6'h0F;
    typedef enum logic [2:0] {
        IDLE,
        L_ON,
        DT_H,
        H_ON,
        DT_L
    } dt_state_t;
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary high/low gate drive with programmable dead time.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int unsigned DT_WIDTH = pwm_deadtime_pkg::DT_WIDTH,
    parameter logic        POL_H    = 1'b1,
    parameter logic        POL_L    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dt_rise,
    input  logic [DT_WIDTH-1:0] dt_fall,
    output logic                pwm_h,
    output logic                pwm_l,
    output logic                dead_active,
    output logic                swallowed
);
    dt_state_t           state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                swal_d;
    logic                pwm_h_q, pwm_l_q, dead_q, swal_q;
    logic                rise_zero, fall_zero, cnt_one;

    assign rise_zero = dt_rise == '0;
    assign fall_zero = dt_fall == '0;
    assign cnt_one   = cnt_q == DT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        swal_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = pwm_in ? (rise_zero ? H_ON : DT_H) : (fall_zero ? L_ON : DT_L);
                    cnt_d   = pwm_in ? dt_rise : dt_fall;
                end
                L_ON: begin
                    state_d = pwm_in ? (rise_zero ? H_ON : DT_H) : L_ON;
                    cnt_d   = pwm_in ? dt_rise : '0;
                end
                H_ON: begin
                    state_d = !pwm_in ? (fall_zero ? L_ON : DT_L) : H_ON;
                    cnt_d   = !pwm_in ? dt_fall : '0;
                end
                // A reversal during a dead phase returns to the side that never left.
                DT_H: begin
                    state_d = !pwm_in ? L_ON : (cnt_one ? H_ON : DT_H);
                    cnt_d   = (!pwm_in || cnt_one) ? '0 : cnt_q - 1'b1;
                    swal_d  = !pwm_in;
                end
                DT_L: begin
                    state_d = pwm_in ? H_ON : (cnt_one ? L_ON : DT_L);
                    cnt_d   = (pwm_in || cnt_one) ? '0 : cnt_q - 1'b1;
                    swal_d  = pwm_in;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pwm_h_q <= ~POL_H;
            pwm_l_q <= ~POL_L;
            dead_q  <= 1'b0;
            swal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_h_q <= (state_d == H_ON) ? POL_H : ~POL_H;
            pwm_l_q <= (state_d == L_ON) ? POL_L : ~POL_L;
            dead_q  <= (state_d == DT_H) || (state_d == DT_L);
            swal_q  <= swal_d;
        end
    end

    assign pwm_h       = pwm_h_q;
    assign pwm_l       = pwm_l_q;
    assign dead_active = dead_q;
    assign swallowed   = swal_q;
endmodule
